// File: rtl/neuron_pkg.sv
// Shared widths, FSM states and the constant weight/bias ROM for neuron_unit.
package neuron_pkg;

  localparam int IN_W    = 12;
  localparam int W_W     = 8;
  localparam int B_W     = 16;
  localparam int OUT_W   = 23;
  localparam int NUM_IDS = 5;

  typedef enum logic [2:0] {
    LOAD,
    MAC0,
    MAC1,
    MAC2,
    OUT
  } state_t;

  localparam int W_TAB [NUM_IDS][3] = '{
    '{ 1,  2,  3},
    '{-1,  1,  0},
    '{ 2, -3,  1},
    '{ 4,  0, -1},
    '{ 0,  0,  0}
  };
  localparam int B_TAB [NUM_IDS] = '{0, 5, -10, 0, 7};

  // Unknown IDs fall back to an all-zero neuron.
  function automatic logic signed [W_W-1:0] get_weight(input int id, input int idx);
    if (id < 0 || id >= NUM_IDS || idx < 0 || idx > 2) return '0;
    return W_W'(W_TAB[id][idx]);
  endfunction

  function automatic logic signed [B_W-1:0] get_bias(input int id);
    if (id < 0 || id >= NUM_IDS) return '0;
    return B_W'(B_TAB[id]);
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Combinational multiply-add: acc_out = acc_in + signed w * unsigned x.
module neuron_mac #(
  parameter int IN_W  = 12,
  parameter int W_W   = 8,
  parameter int OUT_W = 23
) (
  input  logic signed [OUT_W-1:0] acc_in,
  input  logic signed [W_W-1:0]   w,
  input  logic        [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] acc_out
);

  localparam int P_W = W_W + IN_W + 1;

  logic signed [IN_W:0]  x_s;
  logic signed [P_W-1:0] prod;

  // Zero-extend x so the signed multiply never treats it as negative.
  assign x_s     = $signed({1'b0, x});
  assign prod    = P_W'(w) * P_W'(x_s);
  assign acc_out = acc_in + OUT_W'(prod);

endmodule

// File: rtl/neuron_unit.sv
// neuron_unit: 3-input fixed-point neuron, one product per cycle over a 5-state frame.
// Build option: define NEURON_RELU_EN to clamp negative results to zero on out_data.
module neuron_unit #(
  parameter int NEURON_ID = 0,
  parameter int IN_W      = neuron_pkg::IN_W,
  parameter int W_W       = neuron_pkg::W_W,
  parameter int B_W       = neuron_pkg::B_W,
  parameter int OUT_W     = neuron_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data_0,
  input  logic [IN_W-1:0]  in_data_1,
  input  logic [IN_W-1:0]  in_data_2,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid
);

  import neuron_pkg::*;

  localparam logic signed [B_W-1:0] BIAS = B_W'(get_bias(NEURON_ID));

  state_t                  state_q, state_d;
  logic        [IN_W-1:0]  x_q [3];
  logic        [IN_W-1:0]  x_d [3];
  logic        [IN_W-1:0]  in_vec [3];
  logic signed [W_W-1:0]   w_tab [3];
  logic signed [OUT_W-1:0] acc_q, acc_d, mac_sum;
  logic        [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [W_W-1:0]   mac_w;
  logic        [IN_W-1:0]  mac_x;

  assign in_vec[0] = in_data_0;
  assign in_vec[1] = in_data_1;
  assign in_vec[2] = in_data_2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_weight
    assign w_tab[gi] = W_W'(get_weight(NEURON_ID, gi));
  end

  // Operand select kept apart from the next-state logic to avoid a combinational loop.
  always_comb begin
    mac_w = w_tab[0];
    mac_x = x_q[0];
    case (state_q)
      MAC1: begin
        mac_w = w_tab[1];
        mac_x = x_q[1];
      end
      MAC2: begin
        mac_w = w_tab[2];
        mac_x = x_q[2];
      end
      default: ;
    endcase
  end

  neuron_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .acc_in  (acc_q),
    .w       (mac_w),
    .x       (mac_x),
    .acc_out (mac_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < 3; i++) x_d[i] = x_q[i];
    unique case (state_q)
      LOAD: begin
        for (int i = 0; i < 3; i++) x_d[i] = in_vec[i];
        acc_d   = {{(OUT_W-B_W){BIAS[B_W-1]}}, BIAS};
        state_d = MAC0;
      end
      MAC0: begin
        acc_d   = mac_sum;
        state_d = MAC1;
      end
      MAC1: begin
        acc_d   = mac_sum;
        state_d = MAC2;
      end
      MAC2: begin
        acc_d   = mac_sum;
        state_d = OUT;
      end
      OUT: begin
`ifdef NEURON_RELU_EN
        out_data_d = acc_q[OUT_W-1] ? '0 : acc_q;
`else
        out_data_d = acc_q;
`endif
        out_valid_d = 1'b1;
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) x_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 3; i++) x_q[i] <= x_d[i];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_unit.sv
// Self-checking bench: one neuron_unit per ID 0..4, table vectors, random frames, corner sequences.
module tb_neuron_unit;

  localparam int N = 5;

  typedef struct {
    int          id;
    int          x0;
    int          x1;
    int          x2;
    logic [22:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in0 = '0;
  logic [11:0] in1 = '0;
  logic [11:0] in2 = '0;
  logic [22:0] out_data_w  [N];
  logic        out_valid_w [N];

  int checks = 0;
  int errors = 0;

  int wt [N][3] = '{'{1, 2, 3}, '{-1, 1, 0}, '{2, -3, 1}, '{4, 0, -1}, '{0, 0, 0}};
  int bt [N]    = '{0, 5, -10, 0, 7};
  vec_t tbl [5];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    neuron_unit #(.NEURON_ID(gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data_0 (in0),
      .in_data_1 (in1),
      .in_data_2 (in2),
      .out_data  (out_data_w[gi]),
      .out_valid (out_valid_w[gi])
    );
  end

  // Reference: dot product plus bias in plain integers, then activation and 23-bit wrap.
  function automatic logic [22:0] model(input int id, input int x0, input int x1, input int x2);
    int acc;
    acc = bt[id] + wt[id][0] * x0 + wt[id][1] * x1 + wt[id][2] * x2;
`ifdef NEURON_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[22:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at the negedge before a LOAD edge; returns at the negedge after the OUT edge.
  task automatic frame(input int x0, input int x1, input int x2);
    in0 = 12'(x0);
    in1 = 12'(x1);
    in2 = 12'(x2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("frame x=(%0d,%0d,%0d) out=%0h/%0h/%0h/%0h/%0h", x0, x1, x2,
             out_data_w[0], out_data_w[1], out_data_w[2], out_data_w[3], out_data_w[4]);
  endtask

  task automatic check_all(input string tag, input int x0, input int x1, input int x2);
    for (int id = 0; id < N; id++) begin
      chk($sformatf("%s_data_id%0d", tag, id), 32'(out_data_w[id]), 32'(model(id, x0, x1, x2)));
      chk($sformatf("%s_valid_id%0d", tag, id), 32'(out_valid_w[id]), 32'd1);
    end
  endtask

  // Release reset and confirm out_valid rises on exactly the 5th edge with the right data.
  task automatic release_check(input int x0, input int x1, input int x2);
    rst = 1'b1;
    in0 = 12'(x0);
    in1 = 12'(x1);
    in2 = 12'(x2);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("valid_edge%0d", e), 32'(out_valid_w[0]), 32'(e == 5));
    end
    $display("release x=(%0d,%0d,%0d) id0=%0d", x0, x1, x2, out_data_w[0]);
    check_all("release", x0, x1, x2);
  endtask

  initial begin
    tbl[0] = '{0, 10, 20, 30, 23'd140};
    tbl[1] = '{0, 4095, 4095, 4095, 23'd24570};
`ifdef NEURON_RELU_EN
    tbl[2] = '{2, 100, 100, 0, 23'd0};
    tbl[3] = '{1, 4095, 0, 0, 23'd0};
`else
    tbl[2] = '{2, 100, 100, 0, 23'h7FFF92};
    tbl[3] = '{1, 4095, 0, 0, 23'h7FF006};
`endif
    tbl[4] = '{4, 123, 456, 789, 23'd7};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < N; id++) begin
      chk($sformatf("reset_data_id%0d", id), 32'(out_data_w[id]), 32'd0);
      chk($sformatf("reset_valid_id%0d", id), 32'(out_valid_w[id]), 32'd0);
    end

    release_check(10, 20, 30);

    for (int i = 0; i < 5; i++) begin
      frame(tbl[i].x0, tbl[i].x1, tbl[i].x2);
      chk($sformatf("table%0d_id%0d", i, tbl[i].id), 32'(out_data_w[tbl[i].id]), 32'(tbl[i].exp));
    end

    for (int n = 0; n < 20; n++) begin
      int x0, x1, x2;
      x0 = int'($urandom_range(0, 4095));
      x1 = int'($urandom_range(0, 4095));
      x2 = int'($urandom_range(0, 4095));
      frame(x0, x1, x2);
      check_all("rand", x0, x1, x2);
    end

    // Inputs change while MAC1 is pending: this frame keeps (1,1,1), next uses (2,2,2).
    in0 = 12'd1; in1 = 12'd1; in2 = 12'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in0 = 12'd2; in1 = 12'd2; in2 = 12'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("late-change frame id0=%0d", out_data_w[0]);
    chk("late_change_same_frame", 32'(out_data_w[0]), 32'd6);
    frame(2, 2, 2);
    chk("late_change_next_frame", 32'(out_data_w[0]), 32'd12);

    // Reset asserted with MAC2 pending wipes the partial frame.
    in0 = 12'd5; in1 = 12'd5; in2 = 12'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_before_midreset", 32'(out_data_w[0]), 32'd12);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("mid-frame reset id0=%0d valid=%0d", out_data_w[0], out_valid_w[0]);
    chk("midreset_data", 32'(out_data_w[0]), 32'd0);
    chk("midreset_valid", 32'(out_valid_w[0]), 32'd0);
    release_check(1, 2, 3);
    chk("restart_id0", 32'(out_data_w[0]), 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_unit.md
Name: neuron_unit

Overview:
- Single 3-input fixed-point neuron computing ReLU(w0*x0 + w1*x1 + w2*x2 + b).
- Each neuron is instanced several times in a layer, distinguished by NEURON_ID; weights and bias come from a constant table selected by that ID.
- Runs as a free-running, time-multiplexed MAC: one multiplier, one product per cycle.
- Raises out_valid once a result is available, so the layer can compare neuron outputs.

Parameters:
- NEURON_ID, 0: selects the weight/bias row; IDs outside 0..4 use all-zero weights and bias.
- IN_W, 12: input data width (unsigned).
- W_W, 8: weight width (signed two's complement).
- B_W, 16: bias width (signed).
- OUT_W, 23: output/accumulator width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low: state clears on a rising clk edge while rst=0.
- in_data_0  in  12  input x0, unsigned.
- in_data_1  in  12  input x1, unsigned.
- in_data_2  in  12  input x2, unsigned.
- out_data  out  23  activated neuron result.
- out_valid  out  1  high once the first result has been produced.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state<=LOAD, accumulator<=0, out_data<=0, out_valid<=0.
  - Reset takes priority at any point, including mid-frame; a partial frame is discarded.
- FSM, one state per clock, period 5 cycles, repeating forever:
  - LOAD: capture in_data_0..2 into internal registers; acc<=sign-extended bias.
  - MAC0, MAC1, MAC2: acc<=acc+w[i]*x[i] for i=0,1,2.
  - OUT: out_data<=act(acc); out_valid<=1; next state LOAD.
- Latency: result of inputs sampled at a LOAD edge appears on out_data 4 edges later.
  - The first result after reset release appears on the 5th edge.
- Input sampling:
  - Inputs are sampled only in LOAD; changes during MAC0..OUT affect the next frame only.
  - The three inputs are sampled on the same edge.
- Arithmetic:
  - x is zero-extended to 13 bits signed; the product is 21-bit signed.
  - Accumulation is signed, 23 bits, no saturation (worst-case magnitude fits).
- Output timing:
  - out_data holds between OUT edges.
  - out_valid stays 1 until the next reset; it is not a pulse.
- Activation:
  - act(acc) = 0 if acc<0, else acc.
  - out_data is therefore always non-negative, so unsigned comparison downstream is valid.
- Weight table (w0,w1,w2; bias):
  - ID0 (1,2,3;0)
  - ID1 (-1,1,0;5)
  - ID2 (2,-3,1;-10)
  - ID3 (4,0,-1;0)
  - ID4 (0,0,0;7)

Optional Feature:
- Macro: NEURON_RELU_EN.
- Defined: ReLU applied as above.
- Not defined: out_data<=acc unchanged (23-bit two's complement, may be negative). All timing is identical in both cases.

Decomposition:
- Shared package (neuron_pkg) holds:
  - width constants IN_W/W_W/B_W/OUT_W;
  - the weight/bias ROM as a constant function get_weight(id,idx) and get_bias(id);
  - the FSM state enum.
- Sub-module: neuron_mac, a combinational multiply-add (acc + signed w * unsigned x), instanced once. The FSM and registers stay in neuron_unit.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> out_data=0, out_valid=0; release -> out_valid=1 exactly on the 5th edge.
- ID0, x=(10,20,30) -> out_data=140; ID0, x=(4095,4095,4095) -> 24570.
- ID2, x=(100,100,0):
  - with NEURON_RELU_EN -> 0;
  - without -> 23'h7FFF92 (-110).
- ID1, x=(4095,0,0) -> 0 with ReLU (raw -4090). ID4, any x -> 7.
- ID0: change inputs from (1,1,1) to (2,2,2) during MAC1 -> that frame outputs 6, the next frame outputs 12.
- Mid-frame reset:
  - assert rst=0 during MAC2 -> out_data=0, out_valid=0 on that edge;
  - after release, the full 5-cycle frame restarts from LOAD.
